// File: rtl/video_pkg.sv
// Shared video definitions: pixel/coordinate widths, default frame size,
// bounding-box record and the overlay FSM state type.
package video_pkg;

  localparam int RGB_W     = 16;
  localparam int COORD_W   = 12;
  localparam int DEF_IMG_W = 1024;
  localparam int DEF_IMG_H = 720;

  typedef struct packed {
    logic [COORD_W-1:0] x_min;
    logic [COORD_W-1:0] x_max;
    logic [COORD_W-1:0] y_min;
    logic [COORD_W-1:0] y_max;
  } box_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } ovl_state_e;

  // A box is drawable only if it is ordered and lies fully inside the image;
  // the detector's empty-frame marker (x_min=IMG_W, x_max=0) fails here.
  function automatic logic box_ok(input box_t b, input int img_w, input int img_h);
    logic [COORD_W:0] w_lim;
    logic [COORD_W:0] h_lim;
    w_lim = img_w[COORD_W:0];
    h_lim = img_h[COORD_W:0];
    return (b.x_min <= b.x_max) && (b.y_min <= b.y_max) &&
           ({1'b0, b.x_max} < w_lim) && ({1'b0, b.y_max} < h_lim);
  endfunction

endpackage

// File: rtl/frame_pix_counter.sv
// Pixel position tracker for a clken-qualified video stream; frame start is
// the vsync rising edge, which also clears both counters.
module frame_pix_counter
  import video_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vsync,
  input  logic               clken,
  output logic [COORD_W-1:0] cnt_x,
  output logic [COORD_W-1:0] cnt_y,
  output logic               vs_rise
);

  localparam int XL = IMG_W - 1;
  localparam int YL = IMG_H - 1;
  localparam logic [COORD_W-1:0] X_LAST = XL[COORD_W-1:0];
  localparam logic [COORD_W-1:0] Y_LAST = YL[COORD_W-1:0];

  logic vs_d_r;

  assign vs_rise = vsync & ~vs_d_r;

  // vsync history and raster counters; frame start wins over any clken
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d_r <= 1'b0;
      cnt_x  <= '0;
      cnt_y  <= '0;
    end else begin
      vs_d_r <= vsync;
      if (vs_rise) begin
        cnt_x <= '0;
        cnt_y <= '0;
      end else if (clken) begin
        if (cnt_x == X_LAST) begin
          cnt_x <= '0;
          cnt_y <= (cnt_y == Y_LAST) ? {COORD_W{1'b0}} : cnt_y + 12'd1;
        end else begin
          cnt_x <= cnt_x + 12'd1;
        end
      end
    end
  end

endmodule

// File: rtl/face_box_overlay.sv
// Draws the detector's bounding box as a coloured border on the RGB565 stream;
// one box latched per frame with a bounded hold-over, fixed 2-cycle latency.
module face_box_overlay
  import video_pkg::*;
#(
  parameter int          IMG_W       = DEF_IMG_W,
  parameter int          IMG_H       = DEF_IMG_H,
  parameter int          LINE_W      = 2,
  parameter int          HOLD_FRAMES = 8,
  parameter logic [15:0] BOX_COLOR   = 16'hF800
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               per_frame_vsync,
  input  logic               per_frame_href,
  input  logic               per_frame_clken,
  input  logic [RGB_W-1:0]   per_img_data,
  input  logic [COORD_W-1:0] box_x_min,
  input  logic [COORD_W-1:0] box_x_max,
  input  logic [COORD_W-1:0] box_y_min,
  input  logic [COORD_W-1:0] box_y_max,
  output logic               post_frame_vsync,
  output logic               post_frame_href,
  output logic               post_frame_clken,
  output logic [RGB_W-1:0]   post_img_data,
  output logic               box_valid
);

  localparam logic [COORD_W:0] LW        = LINE_W[COORD_W:0];
  localparam logic [7:0]       HOLD_INIT = HOLD_FRAMES[7:0];

  logic [COORD_W-1:0] cnt_x_s;
  logic [COORD_W-1:0] cnt_y_s;
  logic               vs_rise_s;
  box_t               box_in_s;
  logic               box_ok_s;
  logic               inside_s;
  logic               edge_s;
  logic               hit_s;

  ovl_state_e         state_r;
  box_t               shadow_r;
  logic [7:0]         hold_cnt_r;

  logic               vs_s1_r;
  logic               href_s1_r;
  logic               clken_s1_r;
  logic [RGB_W-1:0]   data_s1_r;
  logic               hit_s1_r;

  frame_pix_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .vsync   (per_frame_vsync),
    .clken   (per_frame_clken),
    .cnt_x   (cnt_x_s),
    .cnt_y   (cnt_y_s),
    .vs_rise (vs_rise_s)
  );

  assign box_in_s = '{x_min: box_x_min, x_max: box_x_max,
                      y_min: box_y_min, y_max: box_y_max};
  assign box_ok_s = box_ok(box_in_s, IMG_W, IMG_H);

  // Frame-start box update; the first frame start after reset already samples
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      shadow_r   <= '0;
      hold_cnt_r <= 8'd0;
      box_valid  <= 1'b0;
    end else if (vs_rise_s) begin
      case (state_r)
        ST_IDLE, ST_ACTIVE: begin
          state_r <= ST_ACTIVE;
          if (box_ok_s) begin
            shadow_r   <= box_in_s;
            hold_cnt_r <= HOLD_INIT;
            box_valid  <= 1'b1;
          end else if (hold_cnt_r != 8'd0) begin
            hold_cnt_r <= hold_cnt_r - 8'd1;
          end else begin
            box_valid  <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          box_valid <= 1'b0;
        end
      endcase
    end
  end

  // Border hit test; one bit of headroom so edge sums never wrap
  always_comb begin
    inside_s = box_valid &
               (cnt_x_s >= shadow_r.x_min) & (cnt_x_s <= shadow_r.x_max) &
               (cnt_y_s >= shadow_r.y_min) & (cnt_y_s <= shadow_r.y_max);
    edge_s   = ({1'b0, cnt_x_s} < ({1'b0, shadow_r.x_min} + LW)) |
               (({1'b0, cnt_x_s} + LW) > {1'b0, shadow_r.x_max}) |
               ({1'b0, cnt_y_s} < ({1'b0, shadow_r.y_min} + LW)) |
               (({1'b0, cnt_y_s} + LW) > {1'b0, shadow_r.y_max});
    hit_s    = inside_s & edge_s;
  end

  // Two-stage pipeline: capture stream + hit, then select the output pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_s1_r          <= 1'b0;
      href_s1_r        <= 1'b0;
      clken_s1_r       <= 1'b0;
      data_s1_r        <= '0;
      hit_s1_r         <= 1'b0;
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_data    <= '0;
    end else begin
      vs_s1_r          <= per_frame_vsync;
      href_s1_r        <= per_frame_href;
      clken_s1_r       <= per_frame_clken;
      data_s1_r        <= per_img_data;
      hit_s1_r         <= hit_s;
      post_frame_vsync <= vs_s1_r;
      post_frame_href  <= href_s1_r;
      post_frame_clken <= clken_s1_r;
      post_img_data    <= (hit_s1_r & clken_s1_r) ? BOX_COLOR : data_s1_r;
    end
  end

endmodule

// File: tb/tb_face_box_overlay.sv
// Directed bench: two overlays (LINE_W 1 and 2) on a 16x8 image share the
// stimulus; per-frame vectors carry the expected latched box.
module tb_face_box_overlay;

  logic        clk = 1'b0;
  logic        rst, vsync, href, clken;
  logic [15:0] din;
  logic [11:0] bx0, bx1, by0, by1;
  logic        vs1, hr1, ck1, bv1, vs2, hr2, ck2, bv2;
  logic [15:0] d1, d2;

  always #5 clk = ~clk;

  face_box_overlay #(.IMG_W(16), .IMG_H(8), .LINE_W(1), .HOLD_FRAMES(2), .BOX_COLOR(16'hF800)) u1 (
    .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href),
    .per_frame_clken(clken), .per_img_data(din),
    .box_x_min(bx0), .box_x_max(bx1), .box_y_min(by0), .box_y_max(by1),
    .post_frame_vsync(vs1), .post_frame_href(hr1), .post_frame_clken(ck1),
    .post_img_data(d1), .box_valid(bv1));

  face_box_overlay #(.IMG_W(16), .IMG_H(8), .LINE_W(2), .HOLD_FRAMES(2), .BOX_COLOR(16'hF800)) u2 (
    .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href),
    .per_frame_clken(clken), .per_img_data(din),
    .box_x_min(bx0), .box_x_max(bx1), .box_y_min(by0), .box_y_max(by1),
    .post_frame_vsync(vs2), .post_frame_href(hr2), .post_frame_clken(ck2),
    .post_img_data(d2), .box_valid(bv2));

  typedef struct {
    int          x0, x1, y0, y1;
    logic [15:0] data;
    logic        chg;
    logic        ev;
    int          ex0, ex1, ey0, ey1;
  } vec_t;

  vec_t vecs[9];
  int   n_chk = 0;
  int   n_fail = 0;

  logic        e_valid = 1'b0;
  int          e_x0 = 0, e_x1 = 0, e_y0 = 0, e_y1 = 0;
  logic        h_vs, h_hr, h_ck;
  logic [15:0] h_d1, h_d2;
  int          h_x, h_y;

  function automatic logic on_border(input int x, input int y, input int l);
    int dx, dy;
    if (!e_valid || x < e_x0 || x > e_x1 || y < e_y0 || y > e_y1) return 1'b0;
    dx = (x - e_x0 < e_x1 - x) ? x - e_x0 : e_x1 - x;
    dy = (y - e_y0 < e_y1 - y) ? y - e_y0 : e_y1 - y;
    return (dx < l) || (dy < l);
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: apply inputs, then check the outputs belonging to the previous step
  task automatic step(input logic r, input logic vs, input logic hr, input logic ck,
                      input logic [15:0] d, input int x, input int y);
    logic [15:0] e1, e2;
    rst = r; vsync = vs; href = hr; clken = ck; din = d;
    e1 = (ck && on_border(x, y, 1)) ? 16'hF800 : d;
    e2 = (ck && on_border(x, y, 2)) ? 16'hF800 : d;
    @(posedge clk);
    #1;
    if (r) begin
      chk("reset sync", {10'd0, vs1, hr1, ck1, vs2, hr2, ck2}, 16'd0);
      chk("reset data u1", d1, 16'd0);
      chk("reset data u2", d2, 16'd0);
      chk("reset box_valid", {14'd0, bv1, bv2}, 16'd0);
      h_vs = 1'b0; h_hr = 1'b0; h_ck = 1'b0; h_d1 = 16'd0; h_d2 = 16'd0;
    end else begin
      chk("sync", {10'd0, vs1, hr1, ck1, vs2, hr2, ck2},
          {10'd0, h_vs, h_hr, h_ck, h_vs, h_hr, h_ck});
      chk($sformatf("pix u1 x=%0d y=%0d", h_x, h_y), d1, h_d1);
      chk($sformatf("pix u2 x=%0d y=%0d", h_x, h_y), d2, h_d2);
      h_vs = vs; h_hr = hr; h_ck = ck; h_d1 = e1; h_d2 = e2;
    end
    h_x = x; h_y = y;
  endtask

  task automatic run_line(input int y, input logic [15:0] d, input int x_from);
    for (int x = x_from; x < 16; x++) step(1'b0, 1'b0, 1'b1, 1'b1, d, x, y);
    step(1'b0, 1'b0, 1'b0, 1'b0, d, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, d, 0, 0);
  endtask

  // Frame start with the vector's box on the inputs, then 8 lines of pixels
  task automatic frame_start(input vec_t v);
    bx0 = 12'(v.x0); bx1 = 12'(v.x1); by0 = 12'(v.y0); by1 = 12'(v.y1);
    step(1'b0, 1'b1, 1'b0, 1'b0, v.data, 0, 0);
    e_valid = v.ev; e_x0 = v.ex0; e_x1 = v.ex1; e_y0 = v.ey0; e_y1 = v.ey1;
    chk("box_valid at frame start", {14'd0, bv1, bv2}, {14'd0, v.ev, v.ev});
    step(1'b0, 1'b1, 1'b0, 1'b0, v.data, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, v.data, 0, 0);
  endtask

  task automatic run_frame(input vec_t v);
    frame_start(v);
    for (int y = 0; y < 8; y++) begin
      if (v.chg && y == 3) begin
        bx0 = 12'd1; bx1 = 12'd3; by0 = 12'd1; by1 = 12'd3;
      end
      run_line(y, v.data, 0);
    end
    chk("box_valid at frame end", {14'd0, bv1, bv2}, {14'd0, v.ev, v.ev});
  endtask

  initial begin
    //          x0  x1 y0 y1 data      chg   ev    drawn box
    vecs[0] = '{4,  10, 2, 5, 16'h1234, 1'b0, 1'b1, 4,  10, 2, 5};
    vecs[1] = '{16, 0,  8, 0, 16'h1234, 1'b0, 1'b1, 4,  10, 2, 5};
    vecs[2] = '{16, 0,  8, 0, 16'h1234, 1'b0, 1'b1, 4,  10, 2, 5};
    vecs[3] = '{16, 0,  8, 0, 16'h1234, 1'b0, 1'b0, 0,  0,  0, 0};
    vecs[4] = '{0,  2,  0, 2, 16'h0F0F, 1'b0, 1'b1, 0,  2,  0, 2};
    vecs[5] = '{3,  16, 1, 4, 16'h0F0F, 1'b0, 1'b1, 0,  2,  0, 2};
    vecs[6] = '{12, 15, 4, 7, 16'hAAAA, 1'b1, 1'b1, 12, 15, 4, 7};
    vecs[7] = '{1,  1,  6, 6, 16'h5A5A, 1'b0, 1'b1, 1,  1,  6, 6};
    vecs[8] = '{2,  5,  6, 3, 16'h5A5A, 1'b0, 1'b1, 1,  1,  6, 6};

    bx0 = 12'd0; bx1 = 12'd0; by0 = 12'd0; by1 = 12'd0;
    h_x = 0; h_y = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 0);
    run_line(0, 16'h7777, 0);

    for (int i = 0; i < 9; i++) run_frame(vecs[i]);

    // Reset in the middle of a drawn frame, then recovery on the next frame start
    frame_start('{4, 10, 2, 5, 16'h1234, 1'b0, 1'b1, 4, 10, 2, 5});
    for (int y = 0; y < 3; y++) run_line(y, 16'h1234, 0);
    for (int x = 0; x < 5; x++) step(1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, x, 3);
    step(1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 5, 3);
    e_valid = 1'b0;
    run_line(3, 16'h1234, 6);
    for (int y = 4; y < 8; y++) run_line(y, 16'h1234, 0);
    chk("box_valid after reset", {14'd0, bv1, bv2}, 16'd0);
    run_frame('{5, 7, 1, 6, 16'h5555, 1'b0, 1'b1, 5, 7, 1, 6});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
